iir_result_writer: RTL and testbench

- Downstream stage of the IIR filter. Consumes its output sample stream (write strobe, 16-bit result, write address, finish flag) and buffers it in a small FIFO.
- Writes the buffered results to the result memory through a ready-gated write port, so memory stalls do not lose filter output.
- Tracks the sample count, address-sequence errors and overflow, and raises done once every accepted sample has been written after finish.

---
 rtl/iir_result_writer.sv | 206 ++++++++++++++++++++
 tb/tb_iir_result_writer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : iir_result_writer
// Purpose  : Downstream stage of the IIR filter. Buffers the filter's output
//            sample stream in a small FIFO and writes it to result memory
//            through a ready-gated write port. Tracks the number of written
//            samples, address-sequence errors and FIFO overflow. Raises done
//            once every accepted sample has been written after finish.
// Options  : IIR_WR_PEAK_EN - when defined, adds the peak_abs output. This
//            output holds the largest |in_data| over accepted samples.
// Revision : 1.0 - initial release
// ============================================================================
module iir_result_writer #(
    parameter int DEPTH = 8,   // FIFO entries, power of two, >= 2
    parameter int AW    = 20   // address width
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [15:0]   in_data,
    input  logic [AW-1:0] in_addr,
    input  logic          in_finish,
    input  logic          mem_ready,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_data,
    output logic [AW-1:0] sample_cnt,
    output logic          overflow,
    output logic          addr_err,
`ifdef IIR_WR_PEAK_EN
    output logic [15:0]   peak_abs,
`endif
    output logic          done
);

    // Pointers carry one extra bit so that full and empty can be told apart.
    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_ONE   = {{c_PTR_W{1'b0}}, 1'b1};
    localparam int                c_ENT_W = AW + 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_PTR_W:0]     r_wr_ptr;
    logic [c_PTR_W:0]     r_rd_ptr;
    logic [c_ENT_W-1:0]   r_fifo [DEPTH];
    logic [AW-1:0]        r_exp_addr;

    logic                 w_empty;
    logic                 w_full;
    logic [c_PTR_W:0]     w_level;
    logic                 w_accepting;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic                 w_last_pop;
    logic [c_ENT_W-1:0]   w_head;

    // FIFO status, and the push/pop decisions for this cycle
    always_comb begin
        w_empty     = (r_wr_ptr == r_rd_ptr);
        w_full      = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                      (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
        w_level     = r_wr_ptr - r_rd_ptr;
        w_accepting = (r_state == ST_IDLE) || (r_state == ST_RUN);
        w_push_req  = in_valid && w_accepting;
        w_pop       = !w_empty && mem_ready;
        // A pop frees the head slot on this edge, so a full FIFO can still
        // take a sample when the memory is draining it.
        w_push      = w_push_req && (!w_full || w_pop);
        w_drop      = w_push_req && !w_push;
        w_last_pop  = w_pop && (w_level == c_ONE);
        w_head      = r_fifo[r_rd_ptr[c_PTR_W-1:0]];
    end

    // Sample storage. The contents are not reset because the pointers
    // define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[c_PTR_W-1:0]] <= {in_addr, in_data};
        end
    end

    // Read and write pointers. A reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
        end
    end

    // Registered memory write port and the count of written samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            sample_cnt <= '0;
        end else begin
            mem_wen <= w_pop;
            if (w_pop) begin
                mem_addr   <= w_head[c_ENT_W-1:16];
                mem_data   <= w_head[15:0];
                sample_cnt <= sample_cnt + AW'(1);
            end
        end
    end

    // Sticky overflow, and a check of the address sequence. Dropped samples
    // still advance the expected address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow   <= 1'b0;
            addr_err   <= 1'b0;
            r_exp_addr <= '0;
        end else begin
            if (w_drop) begin
                overflow <= 1'b1;
            end
            if (w_push_req) begin
                if (in_addr != r_exp_addr) begin
                    addr_err <= 1'b1;
                end
                r_exp_addr <= in_addr + AW'(1);
            end
        end
    end

    // Stream-phase control. done is raised on the edge of the final pop, so
    // it lines up with the last mem_wen cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // A sample presented together with finish is kept,
                        // and intake then closes at once.
                        r_state <= in_finish ? ST_DRAIN : ST_RUN;
                    end else if (in_finish) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (in_finish) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty || w_last_pop) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef IIR_WR_PEAK_EN
    logic [15:0] w_abs;

    // Magnitude of the incoming sample. The most negative value saturates,
    // so the result fits the signed positive range.
    always_comb begin
        w_abs = in_data;
        if (in_data == 16'h8000) begin
            w_abs = 16'h7FFF;
        end else if (in_data[15]) begin
            w_abs = 16'h0000 - in_data;
        end
    end

    // Running peak over samples that actually entered the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_abs <= '0;
        end else if (w_push && (w_abs > peak_abs)) begin
            peak_abs <= w_abs;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_iir_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_iir_result_writer
// Purpose  : Directed self-checking bench for iir_result_writer. It checks
//            latency, overflow, full-FIFO push/pop, the address check, reset
//            during a stream and, under IIR_WR_PEAK_EN, the peak_abs output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iir_result_writer;

    localparam int DEPTH = 8;
    localparam int AW    = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [15:0]   in_data;
    logic [AW-1:0] in_addr;
    logic          in_finish;
    logic          mem_ready;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_data;
    logic [AW-1:0] sample_cnt;
    logic          overflow;
    logic          addr_err;
    logic          done;
`ifdef IIR_WR_PEAK_EN
    logic [15:0]   peak_abs;
`endif

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;
    int t0;

    logic [AW+15:0] wq[$];     // observed writes {addr,data}
    int             wc[$];     // cycle of each observed write
    logic [AW+15:0] exp_q[$];  // expected writes

    iir_result_writer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_addr    (in_addr),
        .in_finish  (in_finish),
        .mem_ready  (mem_ready),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .sample_cnt (sample_cnt),
        .overflow   (overflow),
        .addr_err   (addr_err),
`ifdef IIR_WR_PEAK_EN
        .peak_abs   (peak_abs),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every memory write, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_wen) begin
            wq.push_back({mem_addr, mem_data});
            wc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [15:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_finish = 1'b0;
        mem_ready = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        tick();
        tick();
        rst = 1'b0;
        wq.delete();
        wc.delete();
        exp_q.delete();
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40 && !done; i++) tick();
        check(tag, 32'(done), 32'd1);
        tick();  // let the final write be recorded
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, wq.size(), exp_q.size());
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wq[i][AW+15:16]), 32'(exp_q[i][AW+15:16]));
            check($sformatf("%s_data%0d", tag, i), 32'(wq[i][15:0]), 32'(exp_q[i][15:0]));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset values ----------------
        do_reset();
        check("rst_wen",  32'(mem_wen),    32'd0);
        check("rst_addr", 32'(mem_addr),   32'd0);
        check("rst_data", 32'(mem_data),   32'd0);
        check("rst_cnt",  32'(sample_cnt), 32'd0);
        check("rst_ovf",  32'(overflow),   32'd0);
        check("rst_aerr", 32'(addr_err),   32'd0);
        check("rst_done", 32'(done),       32'd0);

        // ---------------- basic stream, latency and done ----------------
        mem_ready = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 4; i++) send(AW'(i), 16'(i + 1));
        in_finish = 1'b1;
        send(AW'(4), 16'd5);
        check("t1_done_early", 32'(done), 32'd0);
        tick();
        check("t1_wen_last",  32'(mem_wen),    32'd1);
        check("t1_data_last", 32'(mem_data),   32'd5);
        check("t1_done",      32'(done),       32'd1);
        check("t1_cnt",       32'(sample_cnt), 32'd5);
        tick();
        check("t1_wen_off",   32'(mem_wen),    32'd0);
        check("t1_done_hold", 32'(done),       32'd1);
        for (int i = 0; i < 5; i++) exp_q.push_back({AW'(i), 16'(i + 1)});
        compare_writes("t1");
        if (wc.size() == 5) begin
            check("t1_latency", wc[0] - t0, 32'd2);
            check("t1_span",    wc[4] - wc[0], 32'd4);
        end else begin
            check("t1_wc_size", wc.size(), 32'd5);
        end
        in_finish = 1'b0;

        // ---------------- overflow with memory stalled ----------------
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(AW'(i), 16'(16'h10 + i));
            if (i == 7) check("t2_ovf_at8", 32'(overflow), 32'd0);
        end
        check("t2_ovf",  32'(overflow), 32'd1);
        check("t2_aerr", 32'(addr_err), 32'd0);
        check("t2_wen",  32'(mem_wen),  32'd0);
        mem_ready = 1'b1;
        in_finish = 1'b1;
        wait_done("t2_done");
        for (int i = 0; i < 8; i++) exp_q.push_back({AW'(i), 16'(16'h10 + i)});
        compare_writes("t2");
        check("t2_cnt", 32'(sample_cnt), 32'd8);

        // ---------------- push and pop on a full FIFO ----------------
        do_reset();
        for (int i = 0; i < 8; i++) send(AW'(i), 16'(16'h20 + i));
        check("t3_ovf_full", 32'(overflow), 32'd0);
        mem_ready = 1'b1;
        send(AW'(8), 16'h28);
        check("t3_ovf_pp", 32'(overflow), 32'd0);
        check("t3_wen",    32'(mem_wen),  32'd1);
        check("t3_head",   32'(mem_data), 32'h20);
        in_finish = 1'b1;
        wait_done("t3_done");
        for (int i = 0; i < 9; i++) exp_q.push_back({AW'(i), 16'(16'h20 + i)});
        compare_writes("t3");
        check("t3_cnt", 32'(sample_cnt), 32'd9);

        // ---------------- address sequence error ----------------
        do_reset();
        mem_ready = 1'b1;
        send(AW'(0), 16'hA0);
        send(AW'(1), 16'hA1);
        check("t4_aerr_ok", 32'(addr_err), 32'd0);
        send(AW'(3), 16'hA3);
        check("t4_aerr", 32'(addr_err), 32'd1);
        send(AW'(4), 16'hA4);
        in_finish = 1'b1;
        wait_done("t4_done");
        exp_q.push_back({AW'(0), 16'hA0});
        exp_q.push_back({AW'(1), 16'hA1});
        exp_q.push_back({AW'(3), 16'hA3});
        exp_q.push_back({AW'(4), 16'hA4});
        compare_writes("t4");

        // ---------------- reset in the middle of a stream ----------------
        do_reset();
        send(AW'(0), 16'h55);
        mem_ready = 1'b1;
        send(AW'(1), 16'h56);
        check("t5_wen_pre",  32'(mem_wen),    32'd1);
        check("t5_data_pre", 32'(mem_data),   32'h55);
        mem_ready = 1'b0;
        send(AW'(2), 16'h57);
        send(AW'(3), 16'h58);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_data", 32'(mem_data),   32'd0);
        check("t5_rst_cnt",  32'(sample_cnt), 32'd0);
        check("t5_rst_wen",  32'(mem_wen),    32'd0);
        wq.delete();
        wc.delete();
        mem_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("t5_no_writes", wq.size(), 32'd0);
        check("t5_cnt_after", 32'(sample_cnt), 32'd0);
        send(AW'(0), 16'h77);
        in_finish = 1'b1;
        wait_done("t5_done");
        exp_q.delete();
        exp_q.push_back({AW'(0), 16'h77});
        compare_writes("t5");
        check("t5_aerr", 32'(addr_err), 32'd0);
        check("t5_ovf",  32'(overflow), 32'd0);

`ifdef IIR_WR_PEAK_EN
        // ---------------- peak magnitude ----------------
        do_reset();
        mem_ready = 1'b1;
        send(AW'(0), 16'h8000);
        send(AW'(1), 16'd100);
        send(AW'(2), 16'hFF38);   // -200
        check("t6_peak_sat", 32'(peak_abs), 32'h7FFF);
        do_reset();
        check("t6_peak_rst", 32'(peak_abs), 32'd0);
        mem_ready = 1'b1;
        send(AW'(0), 16'd5);
        send(AW'(1), 16'hFFF9);   // -7
        check("t6_peak", 32'(peak_abs), 32'd7);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
